// File: rtl/time_set_ctrl_pkg.sv
// Shared types for the clock mode/timing controller.
// Mode encodings are also what the display driver decodes.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    typedef struct packed {
        logic sec_tick;
        logic inc_hour;
        logic inc_min;
        logic clr_sec;
    } strobe_t;

    localparam logic [7:0] CNT8_MAX = 8'hFF;

    function automatic mode_e mode_advance(input mode_e m);
        mode_e r;
        unique case (m)
            MODE_RUN:      r = MODE_SET_HOUR;
            MODE_SET_HOUR: r = MODE_SET_MIN;
            MODE_SET_MIN:  r = MODE_SET_SEC;
            MODE_SET_SEC:  r = MODE_RUN;
            default:       r = MODE_RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, sample-count debounce, press pulse.
// Ports: clk_in/rst (async, active-low), sample_i (100 Hz tick),
//        btn_n_i (raw, active-low), level_o (debounced, active-high), press_o (0->1 pulse).
module btn_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sample_i,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [4:0] DEB_N = 5'(DEB_SAMPLES);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [3:0] cnt_q, cnt_d;
    logic       press_q, press_d;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= ~btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // A sample that disagrees with the accepted level counts toward
    // a flip; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sample_i) begin
            if (sync2_q != level_q) begin
                if ({1'b0, cnt_q} + 5'd1 >= DEB_N) begin
                    level_d = sync2_q;
                    cnt_d   = 4'd0;
                    press_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/timing controller: tick extraction, button handling, RUN/SET FSM, strobes.
// Ports: clk_in, rst (async, active-low), clk_100Hz/clk_10Hz/clk_1Hz (prescaler),
//        btn_mode_n/btn_inc_n (raw), mode, sec_tick/inc_hour/inc_min/clr_sec, blink_on.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES  = 3,
    parameter int HOLD_TICKS   = 10,
    parameter int IDLE_TIMEOUT = 30
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_100Hz,
    input  logic       clk_10Hz,
    input  logic       clk_1Hz,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink_on
);

    localparam logic [7:0] HOLD_N = 8'(HOLD_TICKS);
    localparam logic [7:0] IDLE_N = 8'(IDLE_TIMEOUT);
    localparam logic       IDLE_EN = (IDLE_TIMEOUT != 0);

    logic       armed_q;
    logic       d100_q, d10_q, d1_q;
    logic       t100, t10, t1;
    mode_e      mode_q, mode_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] idle_q, idle_d;
    strobe_t    stb_q, stb_d;

    logic mode_lvl, mode_press;
    logic inc_lvl, inc_press;
    logic in_set, timeout, mode_chg;
    logic repeat_ok, inc_fire;

    // armed_q masks the first cycle after reset so an input that is
    // already high is not mistaken for a rising edge.
    assign t100 = armed_q & clk_100Hz & ~d100_q;
    assign t10  = armed_q & clk_10Hz & ~d10_q;
    assign t1   = armed_q & clk_1Hz & ~d1_q;

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_mode (
        .clk_in  (clk_in),
        .rst     (rst),
        .sample_i(t100),
        .btn_n_i (btn_mode_n),
        .level_o (mode_lvl),
        .press_o (mode_press)
    );

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_inc (
        .clk_in  (clk_in),
        .rst     (rst),
        .sample_i(t100),
        .btn_n_i (btn_inc_n),
        .level_o (inc_lvl),
        .press_o (inc_press)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            d100_q  <= 1'b0;
            d10_q   <= 1'b0;
            d1_q    <= 1'b0;
            mode_q  <= MODE_RUN;
            hold_q  <= 8'd0;
            idle_q  <= 8'd0;
            stb_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            d100_q  <= clk_100Hz;
            d10_q   <= clk_10Hz;
            d1_q    <= clk_1Hz;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        in_set  = (mode_q != MODE_RUN);
        // An INC press in the timeout cycle counts as activity and wins.
        timeout = IDLE_EN && in_set && t1 && !inc_press &&
                  (8'(idle_q + 8'd1) == IDLE_N);

        mode_d = mode_q;
        if (timeout)
            mode_d = MODE_RUN;
        else if (mode_press)
            mode_d = mode_advance(mode_q);
        mode_chg = (mode_d != mode_q);

        hold_d = hold_q;
        if (!inc_lvl || mode_chg)
            hold_d = 8'd0;
        else if (t10 && hold_q != CNT8_MAX)
            hold_d = hold_q + 8'd1;

        idle_d = idle_q;
        if (mode_chg || !in_set || mode_press || inc_press)
            idle_d = 8'd0;
        else if (t1 && idle_q != CNT8_MAX)
            idle_d = idle_q + 8'd1;

        repeat_ok = t10 && inc_lvl && (hold_q >= HOLD_N) &&
                    (mode_q == MODE_SET_HOUR || mode_q == MODE_SET_MIN);
        // A mode change in the same cycle drops any increment.
        inc_fire  = !mode_chg && (inc_press || repeat_ok);

        stb_d          = '0;
        stb_d.sec_tick = t1 && (mode_q == MODE_RUN);
        if (inc_fire) begin
            unique case (mode_q)
                MODE_SET_HOUR: stb_d.inc_hour = 1'b1;
                MODE_SET_MIN:  stb_d.inc_min  = 1'b1;
                MODE_SET_SEC:  stb_d.clr_sec  = 1'b1;
                default:       stb_d          = stb_d;
            endcase
        end
    end

    assign mode     = mode_q;
    assign sec_tick = stb_q.sec_tick;
    assign inc_hour = stb_q.inc_hour;
    assign inc_min  = stb_q.inc_min;
    assign clr_sec  = stb_q.clr_sec;
    assign blink_on = (mode_q == MODE_RUN) ? 1'b1 : d1_q;

endmodule
